// File: rtl/data_req_queue_if.sv
// Data-side request bundle between the MEM-stage requester, the request queue and
// the bridge's SRAM-like data port. The slave modport is the queue's view of it.
interface data_req_queue_if;
    logic        cpu_req_valid;
    logic        cpu_req_ready;
    logic        cpu_wr;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_addr;
    logic [3:0]  cpu_wstrb;
    logic [31:0] cpu_wdata;
    logic        cpu_resp_valid;
    logic        cpu_resp_wr;
    logic [31:0] cpu_resp_rdata;

    logic        sram_req;
    logic        sram_wr;
    logic [1:0]  sram_size;
    logic [31:0] sram_addr;
    logic [3:0]  sram_wstrb;
    logic [31:0] sram_wdata;
    logic        sram_addr_ok;
    logic        sram_data_ok;
    logic [31:0] sram_rdata;

    modport slave (
        input  cpu_req_valid, cpu_wr, cpu_size, cpu_addr, cpu_wstrb, cpu_wdata,
        output cpu_req_ready, cpu_resp_valid, cpu_resp_wr, cpu_resp_rdata,
        output sram_req, sram_wr, sram_size, sram_addr, sram_wstrb, sram_wdata,
        input  sram_addr_ok, sram_data_ok, sram_rdata
    );

    modport master (
        output cpu_req_valid, cpu_wr, cpu_size, cpu_addr, cpu_wstrb, cpu_wdata,
        input  cpu_req_ready, cpu_resp_valid, cpu_resp_wr, cpu_resp_rdata,
        input  sram_req, sram_wr, sram_size, sram_addr, sram_wstrb, sram_wdata,
        output sram_addr_ok, sram_data_ok, sram_rdata
    );
endinterface

// File: rtl/data_req_queue.sv
// In-order data request queue: buffers MEM-stage requests, issues them to the bridge,
// and returns responses in order, silently absorbing those owed to flushed requests.
module data_req_queue #(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cancel,
    data_req_queue_if.slave  bus
);
    localparam int            PW       = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return p + PW'(1);
    endfunction

    // request FIFO storage
    logic              q_wr    [DEPTH];
    logic [1:0]        q_size  [DEPTH];
    logic [31:0]       q_addr  [DEPTH];
    logic [3:0]        q_wstrb [DEPTH];
    logic [31:0]       q_wdata [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       req_cnt;

    // outstanding-transaction tags
    logic [DEPTH-1:0]  tag_wr;
    logic [DEPTH-1:0]  tag_discard;
    logic [PW-1:0]     t_wr_ptr, t_rd_ptr;
    logic [PW:0]       out_cnt;

    logic              push, hs, rsp_pop, resp_fire;
    logic              q_full, q_empty;

    logic              resp_vld_p1;
    logic              resp_wr_p1;
    logic [31:0]       resp_rdata_p1;

    assign q_full  = (req_cnt == FULL_CNT);
    assign q_empty = (req_cnt == '0);

    assign bus.cpu_req_ready = !q_full && !cancel;
    assign push              = bus.cpu_req_valid && bus.cpu_req_ready;

    // ---- stage p0: issue from FIFO head to the bridge ----
    assign bus.sram_req   = !q_empty && (out_cnt != FULL_CNT);
    assign bus.sram_wr    = q_wr[rd_ptr];
    assign bus.sram_size  = q_size[rd_ptr];
    assign bus.sram_addr  = q_addr[rd_ptr];
    assign bus.sram_wstrb = q_wstrb[rd_ptr];
    assign bus.sram_wdata = q_wdata[rd_ptr];

    assign hs        = bus.sram_req && bus.sram_addr_ok;
    assign rsp_pop   = bus.sram_data_ok && (out_cnt != '0);
    assign resp_fire = rsp_pop && !tag_discard[t_rd_ptr] && !cancel;

    always_ff @(posedge clk) begin
        if (push) begin
            q_wr[wr_ptr]    <= bus.cpu_wr;
            q_size[wr_ptr]  <= bus.cpu_size;
            q_addr[wr_ptr]  <= bus.cpu_addr;
            q_wstrb[wr_ptr] <= bus.cpu_wstrb;
            q_wdata[wr_ptr] <= bus.cpu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || cancel) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            req_cnt <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (hs)   rd_ptr <= ptr_inc(rd_ptr);
            unique case ({push, hs})
                2'b10:   req_cnt <= req_cnt + CNT_ONE;
                2'b01:   req_cnt <= req_cnt - CNT_ONE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (hs) tag_wr[t_wr_ptr] <= bus.sram_wr;
    end

    // A flush marks every tag, including one allocated by a handshake in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            t_wr_ptr    <= '0;
            t_rd_ptr    <= '0;
            out_cnt     <= '0;
            tag_discard <= '0;
        end else begin
            if (hs) begin
                t_wr_ptr              <= ptr_inc(t_wr_ptr);
                tag_discard[t_wr_ptr] <= 1'b0;
            end
            if (cancel)  tag_discard <= '1;
            if (rsp_pop) t_rd_ptr    <= ptr_inc(t_rd_ptr);
            unique case ({hs, rsp_pop})
                2'b10:   out_cnt <= out_cnt + CNT_ONE;
                2'b01:   out_cnt <= out_cnt - CNT_ONE;
                default: ;
            endcase
        end
    end

    // ---- stage p1: registered response to the pipeline ----
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_vld_p1   <= 1'b0;
            resp_wr_p1    <= 1'b0;
            resp_rdata_p1 <= '0;
        end else begin
            resp_vld_p1 <= resp_fire;
            if (resp_fire) begin
                resp_wr_p1    <= tag_wr[t_rd_ptr];
                resp_rdata_p1 <= tag_wr[t_rd_ptr] ? 32'h0 : bus.sram_rdata;
            end
        end
    end

    assign bus.cpu_resp_valid = resp_vld_p1;
    assign bus.cpu_resp_wr    = resp_wr_p1;
    assign bus.cpu_resp_rdata = resp_rdata_p1;
endmodule

// File: tb/tb_data_req_queue.sv
// Directed bench for data_req_queue: issue ordering, backpressure, in-order responses,
// cancel/discard behaviour, outstanding-limit gating and mid-operation reset.
module tb_data_req_queue;
    logic clk = 1'b0;
    logic reset;
    logic cancel;
    int   n_tests = 0;
    int   n_fail  = 0;

    data_req_queue_if bus();

    data_req_queue #(.DEPTH(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .cancel (cancel),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        bus.cpu_req_valid = 1'b1;
        bus.cpu_wr        = wr;
        bus.cpu_size      = 2'd2;
        bus.cpu_addr      = addr;
        bus.cpu_wstrb     = wr ? 4'hF : 4'h0;
        bus.cpu_wdata     = wdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        cancel = 1'b0;
        bus.cpu_req_valid = 1'b0;
        bus.cpu_wr = 1'b0;
        bus.cpu_size = 2'd0;
        bus.cpu_addr = '0;
        bus.cpu_wstrb = '0;
        bus.cpu_wdata = '0;
        bus.sram_addr_ok = 1'b0;
        bus.sram_data_ok = 1'b0;
        bus.sram_rdata = '0;
        tick;
        tick;
        reset = 1'b0;
        #1;
        chk1("rst_sram_req", bus.sram_req, 1'b0);
        chk1("rst_resp_valid", bus.cpu_resp_valid, 1'b0);
        chk1("rst_resp_wr", bus.cpu_resp_wr, 1'b0);
        chk32("rst_resp_rdata", bus.cpu_resp_rdata, 32'h0);
        chk1("rst_ready", bus.cpu_req_ready, 1'b1);
        chk32("rst_cnt", 32'(dut.out_cnt), 32'd0);

        // single load, response one cycle after data_ok
        drive_req(1'b0, 32'h1C00_0100, 32'h0);
        #1;
        chk1("t1_ready", bus.cpu_req_ready, 1'b1);
        chk1("t1_req_before_push", bus.sram_req, 1'b0);
        tick;
        bus.cpu_req_valid = 1'b0;
        bus.sram_addr_ok = 1'b1;
        #1;
        chk1("t1_req", bus.sram_req, 1'b1);
        chk32("t1_addr", bus.sram_addr, 32'h1C00_0100);
        chk1("t1_wr", bus.sram_wr, 1'b0);
        chk32("t1_size", 32'(bus.sram_size), 32'd2);
        tick;
        bus.sram_addr_ok = 1'b0;
        #1;
        chk32("t1_cnt_issued", 32'(dut.out_cnt), 32'd1);
        chk1("t1_req_empty", bus.sram_req, 1'b0);
        tick;
        tick;
        bus.sram_data_ok = 1'b1;
        bus.sram_rdata = 32'hDEAD_BEEF;
        #1;
        chk1("t1_no_early_resp", bus.cpu_resp_valid, 1'b0);
        tick;
        bus.sram_data_ok = 1'b0;
        bus.sram_rdata = 32'h0;
        #1;
        chk1("t1_resp_valid", bus.cpu_resp_valid, 1'b1);
        chk1("t1_resp_wr", bus.cpu_resp_wr, 1'b0);
        chk32("t1_resp_rdata", bus.cpu_resp_rdata, 32'hDEAD_BEEF);
        chk32("t1_cnt_done", 32'(dut.out_cnt), 32'd0);
        tick;
        chk1("t1_resp_pulse_end", bus.cpu_resp_valid, 1'b0);
        chk32("t1_rdata_hold", bus.cpu_resp_rdata, 32'hDEAD_BEEF);

        // four stores fill the queue while the bridge refuses
        for (int i = 0; i < 4; i++) begin
            drive_req(1'b1, 32'h0000_00A0 + 32'(4 * i), 32'h1111_0000 + 32'(i));
            #1;
            chk1("t2_ready_fill", bus.cpu_req_ready, 1'b1);
            tick;
        end
        drive_req(1'b1, 32'h0000_00B0, 32'h1111_0004);
        #1;
        chk1("t2_ready_full", bus.cpu_req_ready, 1'b0);
        chk1("t2_req_held", bus.sram_req, 1'b1);
        chk32("t2_addr_head", bus.sram_addr, 32'h0000_00A0);
        chk32("t2_wdata_head", bus.sram_wdata, 32'h1111_0000);
        chk32("t2_wstrb_head", 32'(bus.sram_wstrb), 32'hF);
        chk1("t2_wr_head", bus.sram_wr, 1'b1);
        tick;
        chk1("t2_ready_still_full", bus.cpu_req_ready, 1'b0);
        chk32("t2_addr_stable", bus.sram_addr, 32'h0000_00A0);
        chk32("t2_wdata_stable", bus.sram_wdata, 32'h1111_0000);
        bus.cpu_req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.sram_addr_ok = 1'b1;
            #1;
            chk32("t2_issue_addr", bus.sram_addr, 32'h0000_00A0 + 32'(4 * i));
            tick;
        end
        bus.sram_addr_ok = 1'b0;
        #1;
        chk32("t2_cnt_full", 32'(dut.out_cnt), 32'd4);
        chk1("t2_req_drained", bus.sram_req, 1'b0);
        chk1("t2_ready_back", bus.cpu_req_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            bus.sram_data_ok = 1'b1;
            bus.sram_rdata = 32'hBAD0_0000 + 32'(i);
            tick;
            chk1("t2_resp_valid", bus.cpu_resp_valid, 1'b1);
            chk1("t2_resp_wr", bus.cpu_resp_wr, 1'b1);
            chk32("t2_resp_rdata", bus.cpu_resp_rdata, 32'h0);
        end
        bus.sram_data_ok = 1'b0;
        #1;
        chk32("t2_cnt_zero", 32'(dut.out_cnt), 32'd0);
        tick;
        chk1("t2_resp_end", bus.cpu_resp_valid, 1'b0);

        // store followed by load
        drive_req(1'b1, 32'h0000_0100, 32'h0000_55AA);
        tick;
        drive_req(1'b0, 32'h0000_0200, 32'h0);
        bus.sram_addr_ok = 1'b1;
        #1;
        chk1("t3_store_wr", bus.sram_wr, 1'b1);
        chk32("t3_store_wdata", bus.sram_wdata, 32'h0000_55AA);
        tick;
        bus.cpu_req_valid = 1'b0;
        #1;
        chk1("t3_load_req", bus.sram_req, 1'b1);
        chk1("t3_load_wr", bus.sram_wr, 1'b0);
        chk32("t3_load_addr", bus.sram_addr, 32'h0000_0200);
        tick;
        bus.sram_addr_ok = 1'b0;
        bus.sram_data_ok = 1'b1;
        bus.sram_rdata = 32'hFFFF_FFFF;
        tick;
        chk1("t3_st_resp_valid", bus.cpu_resp_valid, 1'b1);
        chk1("t3_st_resp_wr", bus.cpu_resp_wr, 1'b1);
        chk32("t3_st_resp_rdata", bus.cpu_resp_rdata, 32'h0);
        bus.sram_rdata = 32'h1234_5678;
        tick;
        chk1("t3_ld_resp_valid", bus.cpu_resp_valid, 1'b1);
        chk1("t3_ld_resp_wr", bus.cpu_resp_wr, 1'b0);
        chk32("t3_ld_resp_rdata", bus.cpu_resp_rdata, 32'h1234_5678);
        bus.sram_data_ok = 1'b0;
        tick;

        // 3 issued + 2 queued, then cancel
        drive_req(1'b0, 32'h0000_0300, 32'h0);
        tick;
        for (int i = 1; i < 4; i++) begin
            drive_req(1'b0, 32'h0000_0300 + 32'(4 * i), 32'h0);
            bus.sram_addr_ok = 1'b1;
            #1;
            chk32("t4_issue_addr", bus.sram_addr, 32'h0000_0300 + 32'(4 * (i - 1)));
            tick;
        end
        drive_req(1'b0, 32'h0000_0310, 32'h0);
        bus.sram_addr_ok = 1'b0;
        tick;
        bus.cpu_req_valid = 1'b0;
        #1;
        chk32("t4_cnt_three", 32'(dut.out_cnt), 32'd3);
        chk1("t4_req_pending", bus.sram_req, 1'b1);
        chk32("t4_head_addr", bus.sram_addr, 32'h0000_030C);
        drive_req(1'b0, 32'h0000_0400, 32'h0);
        cancel = 1'b1;
        #1;
        chk1("t4_ready_cancel", bus.cpu_req_ready, 1'b0);
        tick;
        cancel = 1'b0;
        bus.cpu_req_valid = 1'b0;
        #1;
        chk1("t4_queue_cleared", bus.sram_req, 1'b0);
        chk32("t4_cnt_kept", 32'(dut.out_cnt), 32'd3);
        chk1("t4_ready_after", bus.cpu_req_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            bus.sram_data_ok = 1'b1;
            bus.sram_rdata = 32'h5555_0000 + 32'(i);
            tick;
            chk1("t4_resp_suppressed", bus.cpu_resp_valid, 1'b0);
        end
        bus.sram_data_ok = 1'b0;
        #1;
        chk32("t4_cnt_zero", 32'(dut.out_cnt), 32'd0);
        chk32("t4_rdata_hold", bus.cpu_resp_rdata, 32'h1234_5678);
        tick;

        // cancel coincident with the head handshake
        drive_req(1'b0, 32'h0000_0500, 32'h0);
        tick;
        bus.cpu_req_valid = 1'b0;
        bus.sram_addr_ok = 1'b1;
        cancel = 1'b1;
        #1;
        chk1("t5_req_in_cancel", bus.sram_req, 1'b1);
        tick;
        bus.sram_addr_ok = 1'b0;
        cancel = 1'b0;
        drive_req(1'b0, 32'h0000_0600, 32'h0);
        #1;
        chk32("t5_cnt_one", 32'(dut.out_cnt), 32'd1);
        chk1("t5_req_empty", bus.sram_req, 1'b0);
        tick;
        bus.cpu_req_valid = 1'b0;
        bus.sram_addr_ok = 1'b1;
        #1;
        chk1("t5_new_req", bus.sram_req, 1'b1);
        chk32("t5_new_addr", bus.sram_addr, 32'h0000_0600);
        tick;
        bus.sram_addr_ok = 1'b0;
        bus.sram_data_ok = 1'b1;
        bus.sram_rdata = 32'h0000_0BAD;
        tick;
        chk1("t5_old_suppressed", bus.cpu_resp_valid, 1'b0);
        chk32("t5_cnt_after_old", 32'(dut.out_cnt), 32'd1);
        bus.sram_rdata = 32'hCAFE_F00D;
        tick;
        chk1("t5_new_resp_valid", bus.cpu_resp_valid, 1'b1);
        chk1("t5_new_resp_wr", bus.cpu_resp_wr, 1'b0);
        chk32("t5_new_resp_rdata", bus.cpu_resp_rdata, 32'hCAFE_F00D);
        bus.sram_data_ok = 1'b0;
        #1;
        chk32("t5_cnt_zero", 32'(dut.out_cnt), 32'd0);
        tick;

        // simultaneous handshake and data_ok at DEPTH-1, then the outstanding limit
        drive_req(1'b0, 32'h0000_0700, 32'h0);
        tick;
        for (int i = 1; i < 4; i++) begin
            drive_req(1'b0, 32'h0000_0700 + 32'(4 * i), 32'h0);
            bus.sram_addr_ok = 1'b1;
            tick;
        end
        drive_req(1'b0, 32'h0000_0710, 32'h0);
        bus.sram_addr_ok = 1'b0;
        tick;
        bus.cpu_req_valid = 1'b0;
        bus.sram_addr_ok = 1'b1;
        bus.sram_data_ok = 1'b1;
        bus.sram_rdata = 32'h1111_1111;
        #1;
        chk1("t6_req_at3", bus.sram_req, 1'b1);
        chk32("t6_addr_at3", bus.sram_addr, 32'h0000_070C);
        tick;
        chk32("t6_cnt_unchanged", 32'(dut.out_cnt), 32'd3);
        chk1("t6_req_still", bus.sram_req, 1'b1);
        chk32("t6_next_addr", bus.sram_addr, 32'h0000_0710);
        chk1("t6_resp_valid", bus.cpu_resp_valid, 1'b1);
        chk32("t6_resp_rdata", bus.cpu_resp_rdata, 32'h1111_1111);
        bus.sram_data_ok = 1'b0;
        tick;
        bus.sram_addr_ok = 1'b0;
        drive_req(1'b0, 32'h0000_0714, 32'h0);
        #1;
        chk32("t6_cnt_full", 32'(dut.out_cnt), 32'd4);
        tick;
        bus.cpu_req_valid = 1'b0;
        bus.sram_addr_ok = 1'b1;
        #1;
        chk1("t6_req_blocked", bus.sram_req, 1'b0);
        tick;
        chk32("t6_cnt_no_issue", 32'(dut.out_cnt), 32'd4);
        bus.sram_addr_ok = 1'b0;
        bus.sram_data_ok = 1'b1;
        bus.sram_rdata = 32'h2222_2222;
        tick;
        chk32("t6_resp_p1", bus.cpu_resp_rdata, 32'h2222_2222);
        chk1("t6_req_unblocked", bus.sram_req, 1'b1);
        chk32("t6_unblocked_addr", bus.sram_addr, 32'h0000_0714);
        bus.sram_data_ok = 1'b0;
        bus.sram_addr_ok = 1'b1;
        tick;
        bus.sram_addr_ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.sram_data_ok = 1'b1;
            bus.sram_rdata = 32'h3333_0000 + 32'(i);
            tick;
            chk1("t6_drain_valid", bus.cpu_resp_valid, 1'b1);
            chk32("t6_drain_rdata", bus.cpu_resp_rdata, 32'h3333_0000 + 32'(i));
        end
        bus.sram_data_ok = 1'b1;
        bus.sram_rdata = 32'h4444_4444;
        tick;
        chk32("t6_stray_cnt", 32'(dut.out_cnt), 32'd0);
        chk1("t6_stray_no_resp", bus.cpu_resp_valid, 1'b0);
        bus.sram_data_ok = 1'b0;
        tick;

        // reset in the middle of traffic
        drive_req(1'b0, 32'h0000_0800, 32'h0);
        tick;
        bus.cpu_req_valid = 1'b0;
        bus.sram_addr_ok = 1'b1;
        tick;
        bus.sram_addr_ok = 1'b0;
        drive_req(1'b0, 32'h0000_0804, 32'h0);
        tick;
        bus.cpu_req_valid = 1'b0;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        #1;
        chk32("t7_cnt_cleared", 32'(dut.out_cnt), 32'd0);
        chk1("t7_req_cleared", bus.sram_req, 1'b0);
        chk1("t7_ready", bus.cpu_req_ready, 1'b1);
        chk32("t7_rdata_cleared", bus.cpu_resp_rdata, 32'h0);
        bus.sram_data_ok = 1'b1;
        bus.sram_rdata = 32'h9999_9999;
        tick;
        chk1("t7_late_data_ok", bus.cpu_resp_valid, 1'b0);
        chk32("t7_cnt_stays", 32'(dut.out_cnt), 32'd0);
        bus.sram_data_ok = 1'b0;
        tick;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
